// File: rtl/synth_pkg.sv
// Shared synth definitions: command encodings, special note codes, waveform
// indices and the reference voice record layout at default widths.
package synth_pkg;

  localparam logic CMD_NOTE_ON  = 1'b1;
  localparam logic CMD_NOTE_OFF = 1'b0;

  // Special note values at the default 7-bit MIDI width.
  localparam logic [6:0] NOTE_CHANGE_WAVE = 7'h00;
  localparam logic [6:0] NOTE_STOP_ALL    = 7'h7F;

  // Bit positions in the one-hot waveform select.
  localparam int unsigned SINE     = 0;
  localparam int unsigned SQUARE   = 1;
  localparam int unsigned SAWTOOTH = 2;
  localparam int unsigned TRIANGLE = 3;

  // Voice record at default widths (7-bit note, 8-bit velocity, 16 voices).
  typedef struct packed {
    logic [6:0] note;
    logic [7:0] vel;
    logic [3:0] age;
  } voice_t;

endpackage

// File: rtl/voice_allocator_p_if.sv
// Command and dispatch bus of voice_allocator_p. The master drives commands and
// observes dispatch; the slave is the allocator.
interface voice_allocator_p_if #(
  parameter int unsigned NVOICES = 16,
  parameter int unsigned MIDI_W  = 7,
  parameter int unsigned VEL_W   = 8,
  parameter int unsigned NWAVES  = 4
);
  localparam int unsigned IDX_W = $clog2(NVOICES);

  logic                    i_valid;
  logic [MIDI_W+VEL_W:0]   i_data;
  logic [MIDI_W-1:0]       o_midi;
  logic [VEL_W-1:0]        o_velocity;
  logic [IDX_W-1:0]        o_voice_idx;
  logic                    o_valid;
  logic [NWAVES-1:0]       o_wave_sel;
  logic [IDX_W:0]          o_active_cnt;
  logic                    o_steal;

  modport master (
    output i_valid, i_data,
    input  o_midi, o_velocity, o_voice_idx, o_valid, o_wave_sel, o_active_cnt, o_steal
  );

  modport slave (
    input  i_valid, i_data,
    output o_midi, o_velocity, o_voice_idx, o_valid, o_wave_sel, o_active_cnt, o_steal
  );

endinterface

// File: rtl/voice_allocator_p_voice_pick.sv
// Combinational slot search: lowest free slot, lowest slot holding a note,
// and the oldest active slot (lowest index on equal age).
module voice_pick #(
  parameter  int unsigned NVOICES = 16,
  parameter  int unsigned MIDI_W  = 7,
  localparam int unsigned IDX_W   = $clog2(NVOICES)
) (
  input  logic [NVOICES-1:0][MIDI_W-1:0] notes_i,
  input  logic [NVOICES-1:0][IDX_W-1:0]  ages_i,
  input  logic [MIDI_W-1:0]              note_i,
  output logic [IDX_W-1:0]               free_idx_o,
  output logic                           free_found_o,
  output logic [IDX_W-1:0]               match_idx_o,
  output logic                           match_found_o,
  output logic [IDX_W-1:0]               oldest_idx_o
);

  logic [IDX_W-1:0] oldest_age;
  logic             oldest_found;

  // Ascending scans; the first hit wins so ties resolve to the lowest index.
  always_comb begin
    free_idx_o    = '0;
    free_found_o  = 1'b0;
    match_idx_o   = '0;
    match_found_o = 1'b0;
    oldest_idx_o  = '0;
    oldest_age    = '0;
    oldest_found  = 1'b0;
    for (int i = 0; i < int'(NVOICES); i++) begin
      if (notes_i[i] == '0) begin
        if (!free_found_o) begin
          free_found_o = 1'b1;
          free_idx_o   = IDX_W'(i);
        end
      end else begin
        if (!match_found_o && (notes_i[i] == note_i)) begin
          match_found_o = 1'b1;
          match_idx_o   = IDX_W'(i);
        end
        if (!oldest_found || (ages_i[i] > oldest_age)) begin
          oldest_found = 1'b1;
          oldest_age   = ages_i[i];
          oldest_idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/voice_allocator_p.sv
// Polyphonic voice allocator: NVOICES slots of {note, vel, age}, note-on/off
// handling, waveform cycling and round-robin dispatch on clk_en.
// Optional macro VOICE_STEAL_EN: a note-on with a full table replaces the
// oldest voice and pulses o_steal; otherwise such a note-on is dropped.
module voice_allocator_p
  import synth_pkg::*;
#(
  parameter int unsigned NVOICES = 16,
  parameter int unsigned MIDI_W  = 7,
  parameter int unsigned VEL_W   = 8,
  parameter int unsigned NWAVES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  voice_allocator_p_if.slave bus
);

  localparam int unsigned      IDX_W    = $clog2(NVOICES);
  localparam int unsigned      CNT_W    = IDX_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVOICES - 1);
  localparam logic [NWAVES-1:0] WAVE_RST = NWAVES'(1) << SINE;

  logic [NVOICES-1:0][MIDI_W-1:0] note_q, note_d;
  logic [NVOICES-1:0][VEL_W-1:0]  vel_q, vel_d;
  logic [NVOICES-1:0][IDX_W-1:0]  age_q, age_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [MIDI_W-1:0]              midi_q, midi_d;
  logic [VEL_W-1:0]               velo_q, velo_d;
  logic [IDX_W-1:0]               vidx_q, vidx_d;
  logic                           valid_q, valid_d;
  logic [NWAVES-1:0]              wave_q, wave_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           steal_q, steal_d;

  logic                           cmd_bit;
  logic [MIDI_W-1:0]              cmd_note;
  logic [VEL_W-1:0]               cmd_vel;
  logic [IDX_W-1:0]               free_idx, match_idx, oldest_idx;
  logic                           free_found, match_found;
  logic                           place_en, retrig_en, release_en, clear_all;
  logic [IDX_W-1:0]               place_idx;

  assign cmd_bit  = bus.i_data[MIDI_W+VEL_W];
  assign cmd_note = bus.i_data[VEL_W +: MIDI_W];
  assign cmd_vel  = bus.i_data[VEL_W-1:0];

  voice_pick #(
    .NVOICES (NVOICES),
    .MIDI_W  (MIDI_W)
  ) u_pick (
    .notes_i       (note_q),
    .ages_i        (age_q),
    .note_i        (cmd_note),
    .free_idx_o    (free_idx),
    .free_found_o  (free_found),
    .match_idx_o   (match_idx),
    .match_found_o (match_found),
    .oldest_idx_o  (oldest_idx)
  );

  // Command decode into one table action per cycle.
  always_comb begin
    place_en   = 1'b0;
    place_idx  = '0;
    retrig_en  = 1'b0;
    release_en = 1'b0;
    clear_all  = 1'b0;
    steal_d    = 1'b0;
    wave_d     = wave_q;
    if (bus.i_valid) begin
      if (cmd_bit == CMD_NOTE_ON) begin
        if (cmd_note == '0) begin
          // Note 0 with velocity 0 is CHANGE_WAVE; with a velocity it is ignored.
          if (cmd_vel == '0) wave_d = {wave_q[NWAVES-2:0], wave_q[NWAVES-1]};
        end else if (cmd_vel == '0) begin
          release_en = match_found;
        end else if (match_found) begin
          retrig_en = 1'b1;
        end else if (free_found) begin
          place_en  = 1'b1;
          place_idx = free_idx;
        end else begin
`ifdef VOICE_STEAL_EN
          place_en  = 1'b1;
          place_idx = oldest_idx;
          steal_d   = 1'b1;
`else
          place_en  = 1'b0;
`endif
        end
      end else begin
        if (cmd_note == '1) clear_all = 1'b1;
        else if (cmd_note != '0) release_en = match_found;
      end
    end
  end

  // Voice table next state: placement, retrigger, release or full clear.
  always_comb begin
    note_d = note_q;
    vel_d  = vel_q;
    age_d  = age_q;
    for (int i = 0; i < int'(NVOICES); i++) begin
      if (clear_all) begin
        note_d[i] = '0;
        vel_d[i]  = '0;
        age_d[i]  = '0;
      end else if (place_en) begin
        if (i == int'(place_idx)) begin
          note_d[i] = cmd_note;
          vel_d[i]  = cmd_vel;
          age_d[i]  = '0;
        end else if ((note_q[i] != '0) && (age_q[i] != IDX_LAST)) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end else if (retrig_en) begin
        // Only voices younger than the retriggered one age, keeping order intact.
        if (i == int'(match_idx)) begin
          vel_d[i] = cmd_vel;
          age_d[i] = '0;
        end else if ((note_q[i] != '0) && (age_q[i] < age_q[match_idx])) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end else if (release_en && (i == int'(match_idx))) begin
        note_d[i] = '0;
        vel_d[i]  = '0;
        age_d[i]  = '0;
      end
    end
  end

  // Occupancy count from the current table; visible one cycle after a change.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < int'(NVOICES); i++) begin
      if (note_q[i] != '0) cnt_d = cnt_d + 1'b1;
    end
  end

  // Round-robin dispatch from the pre-update table on each clk_en tick.
  always_comb begin
    idx_d   = idx_q;
    midi_d  = midi_q;
    velo_d  = velo_q;
    vidx_d  = vidx_q;
    valid_d = valid_q;
    if (clk_en) begin
      midi_d  = note_q[idx_q];
      velo_d  = vel_q[idx_q];
      vidx_d  = idx_q;
      valid_d = (note_q[idx_q] != '0);
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_q  <= '0;
      vel_q   <= '0;
      age_q   <= '0;
      idx_q   <= '0;
      midi_q  <= '0;
      velo_q  <= '0;
      vidx_q  <= '0;
      valid_q <= 1'b0;
      wave_q  <= WAVE_RST;
      cnt_q   <= '0;
      steal_q <= 1'b0;
    end else begin
      note_q  <= note_d;
      vel_q   <= vel_d;
      age_q   <= age_d;
      idx_q   <= idx_d;
      midi_q  <= midi_d;
      velo_q  <= velo_d;
      vidx_q  <= vidx_d;
      valid_q <= valid_d;
      wave_q  <= wave_d;
      cnt_q   <= cnt_d;
      steal_q <= steal_d;
    end
  end

  assign bus.o_midi       = midi_q;
  assign bus.o_velocity   = velo_q;
  assign bus.o_voice_idx  = vidx_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_wave_sel   = wave_q;
  assign bus.o_active_cnt = cnt_q;
  assign bus.o_steal      = steal_q;

endmodule
